// File: rtl/sram_port_arbiter.sv
// Arbitrates the single-port pixel SRAM between a buffered write stream and a
// request/grant read port with fixed-latency data return.
module sram_port_arbiter #(
  parameter int WBUF_DEPTH = 4,
  parameter int SRAM_LAT   = 1,
  parameter int AW         = 20,
  parameter int DW         = 24
) (
  input  logic          Clk_in,
  input  logic          Reset_n,
  input  logic          SRAM_EN_w,
  input  logic          SRAM_WE_w,
  input  logic [AW-1:0] SRAM_Addr_w,
  input  logic [DW-1:0] SRAM_Din,
  input  logic          write_finish,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_gnt,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          SRAM_EN,
  output logic          SRAM_WE,
  output logic [AW-1:0] SRAM_Addr,
  output logic [DW-1:0] SRAM_D,
  input  logic [DW-1:0] SRAM_Q,
  output logic          wbuf_overflow,
  output logic          all_written
);

  localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CW = $clog2(WBUF_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(WBUF_DEPTH);
  localparam logic [CW-1:0] FORCE_C  = CW'(WBUF_DEPTH - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(WBUF_DEPTH - 1);

  logic [AW-1:0]       addr_mem [WBUF_DEPTH];
  logic [DW-1:0]       data_mem [WBUF_DEPTH];
  logic [PW-1:0]       wptr;
  logic [PW-1:0]       rptr;
  logic [CW-1:0]       count;
  logic                last_gnt;
  logic [SRAM_LAT-1:0] vld_p;

  logic push;
  logic push_ok;
  logic gnt_w;
  logic gnt_r;
  logic rd_cmd;

  // Pointers wrap explicitly so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign push    = SRAM_EN_w & SRAM_WE_w;
  assign push_ok = push & ((count < DEPTH_C) | gnt_w);
  assign rd_gnt  = gnt_r;
  assign rd_cmd  = SRAM_EN & ~SRAM_WE;

  // A nearly full buffer always wins; otherwise contention alternates.
  always_comb begin
    gnt_w = 1'b0;
    gnt_r = 1'b0;
    if (Reset_n) begin
      if (count >= FORCE_C) begin
        gnt_w = 1'b1;
      end else if ((count != '0) && rd_req) begin
        gnt_w = last_gnt;
        gnt_r = ~last_gnt;
      end else if (count != '0) begin
        gnt_w = 1'b1;
      end else if (rd_req) begin
        gnt_r = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk_in) begin
    if (push_ok) begin
      addr_mem[wptr] <= SRAM_Addr_w;
      data_mem[wptr] <= SRAM_Din;
    end
  end

  // p0: arbitration result becomes the registered SRAM command
  always_ff @(posedge Clk_in) begin
    if (!Reset_n) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      last_gnt      <= 1'b1;
      SRAM_EN       <= 1'b0;
      SRAM_WE       <= 1'b0;
      wbuf_overflow <= 1'b0;
      all_written   <= 1'b0;
    end else begin
      if (push_ok) wptr <= ptr_inc(wptr);
      if (gnt_w)   rptr <= ptr_inc(rptr);
      count <= count + CW'(push_ok) - CW'(gnt_w);
      if (gnt_w)      last_gnt <= 1'b0;
      else if (gnt_r) last_gnt <= 1'b1;
      if (push && !push_ok) wbuf_overflow <= 1'b1;
      if (write_finish && (count == '0) && !push && !(SRAM_EN && SRAM_WE))
        all_written <= 1'b1;
      SRAM_EN <= gnt_w | gnt_r;
      SRAM_WE <= gnt_w;
    end
  end

  always_ff @(posedge Clk_in) begin
    if (!Reset_n) begin
      SRAM_Addr <= '0;
      SRAM_D    <= '0;
    end else if (gnt_w) begin
      SRAM_Addr <= addr_mem[rptr];
      SRAM_D    <= data_mem[rptr];
    end else if (gnt_r) begin
      SRAM_Addr <= rd_addr;
    end
  end

  // p1..pN: read tag follows the command until SRAM_Q is valid
  always_ff @(posedge Clk_in) begin
    if (!Reset_n) begin
      vld_p    <= '0;
      rd_valid <= 1'b0;
    end else begin
      vld_p[0] <= rd_cmd;
      for (int i = 1; i < SRAM_LAT; i++) vld_p[i] <= vld_p[i-1];
      rd_valid <= vld_p[SRAM_LAT-1];
    end
  end

  always_ff @(posedge Clk_in) begin
    if (!Reset_n)                    rd_data <= '0;
    else if (vld_p[SRAM_LAT-1])      rd_data <= SRAM_Q;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: a queue-based reference model of the buffer,
// arbitration and read return is compared against the DUT every cycle.
module tb_sram_port_arbiter;
  localparam int AW  = 20;
  localparam int DW  = 24;
  localparam int LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          Reset_n = 1'b0;
  logic          SRAM_EN_w = 1'b0, SRAM_WE_w = 1'b0, write_finish = 1'b0, rd_req = 1'b0;
  logic [AW-1:0] SRAM_Addr_w = '0, rd_addr = '0;
  logic [DW-1:0] SRAM_Din = '0;
  logic [DW-1:0] sram_q;
  logic          sel = 1'b0;

  logic          a_gnt, a_rv, a_en, a_we, a_ovf, a_aw;
  logic [DW-1:0] a_rd, a_d;
  logic [AW-1:0] a_addr;
  logic          b_gnt, b_rv, b_en, b_we, b_ovf, b_aw;
  logic [DW-1:0] b_rd, b_d;
  logic [AW-1:0] b_addr;

  sram_port_arbiter #(.WBUF_DEPTH(4), .SRAM_LAT(LAT), .AW(AW), .DW(DW)) dut_a (
    .Clk_in(clk), .Reset_n(Reset_n), .SRAM_EN_w(SRAM_EN_w), .SRAM_WE_w(SRAM_WE_w),
    .SRAM_Addr_w(SRAM_Addr_w), .SRAM_Din(SRAM_Din), .write_finish(write_finish),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(a_gnt), .rd_valid(a_rv), .rd_data(a_rd),
    .SRAM_EN(a_en), .SRAM_WE(a_we), .SRAM_Addr(a_addr), .SRAM_D(a_d), .SRAM_Q(sram_q),
    .wbuf_overflow(a_ovf), .all_written(a_aw));

  sram_port_arbiter #(.WBUF_DEPTH(2), .SRAM_LAT(LAT), .AW(AW), .DW(DW)) dut_b (
    .Clk_in(clk), .Reset_n(Reset_n), .SRAM_EN_w(SRAM_EN_w), .SRAM_WE_w(SRAM_WE_w),
    .SRAM_Addr_w(SRAM_Addr_w), .SRAM_Din(SRAM_Din), .write_finish(write_finish),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(b_gnt), .rd_valid(b_rv), .rd_data(b_rd),
    .SRAM_EN(b_en), .SRAM_WE(b_we), .SRAM_Addr(b_addr), .SRAM_D(b_d), .SRAM_Q(sram_q),
    .wbuf_overflow(b_ovf), .all_written(b_aw));

  wire          o_gnt  = sel ? b_gnt  : a_gnt;
  wire          o_rv   = sel ? b_rv   : a_rv;
  wire          o_en   = sel ? b_en   : a_en;
  wire          o_we   = sel ? b_we   : a_we;
  wire          o_ovf  = sel ? b_ovf  : a_ovf;
  wire          o_aw   = sel ? b_aw   : a_aw;
  wire [DW-1:0] o_rd   = sel ? b_rd   : a_rd;
  wire [DW-1:0] o_d    = sel ? b_d    : a_d;
  wire [AW-1:0] o_addr = sel ? b_addr : a_addr;

  // SRAM behavioural model, driven by whichever DUT is selected.
  bit [DW-1:0] sram [65536];
  always @(posedge clk) begin
    if (o_en === 1'b1 && o_we === 1'b1) sram[o_addr[15:0]] <= o_d;
    if (o_en === 1'b1 && o_we === 1'b0) sram_q <= sram[o_addr[15:0]];
  end

  // Reference model state.
  logic [AW+DW-1:0] wq[$];
  int               due_q[$];
  logic [DW-1:0]    dat_q[$];
  bit [DW-1:0]      ref_mem [65536];
  int               cyc = 0;
  int               m_depth = 4;
  bit               m_last;
  logic             e_en, e_we, e_rv, e_ovf, e_aw, e_gr;
  logic [AW-1:0]    e_addr;
  logic [DW-1:0]    e_d, e_rd;

  wire [72:0] outs = {o_en, o_we, o_addr, o_d, o_rv, o_rd, o_ovf, o_aw};
  wire [72:0] exps = {e_en, e_we, e_addr, e_d, e_rv, e_rd, e_ovf, e_aw};

  int n_cmp = 0;
  int n_bad = 0;

  // Evaluates one cycle from the current inputs: sets e_gr for this cycle
  // and the expected registered outputs for the next cycle.
  task automatic ref_cycle();
    bit push, gw, gr, acc;
    int sz;
    logic [AW+DW-1:0] h;
    if (Reset_n !== 1'b1) begin
      wq.delete(); due_q.delete(); dat_q.delete();
      m_last = 1'b1;
      {e_en, e_we, e_addr, e_d, e_rv, e_rd, e_ovf, e_aw} = '0;
      e_gr = 1'b0;
      cyc++;
      return;
    end
    sz   = wq.size();
    push = SRAM_EN_w & SRAM_WE_w;
    gw = 0; gr = 0;
    if (sz >= m_depth - 1)          gw = 1;
    else if (sz != 0 && rd_req)     begin if (m_last) gw = 1; else gr = 1; end
    else if (sz != 0)               gw = 1;
    else if (rd_req)                gr = 1;
    e_gr = gr;
    if (write_finish && sz == 0 && !push && !(e_en && e_we)) e_aw = 1'b1;
    acc = push && (sz < m_depth || gw);
    if (push && !acc) e_ovf = 1'b1;
    if (gw) begin
      h = wq.pop_front();
      e_en = 1; e_we = 1; e_addr = h[AW+DW-1:DW]; e_d = h[DW-1:0];
      ref_mem[e_addr[15:0]] = e_d;
      m_last = 0;
    end else if (gr) begin
      e_en = 1; e_we = 0; e_addr = rd_addr;
      due_q.push_back(cyc + 2 + LAT);
      dat_q.push_back(ref_mem[rd_addr[15:0]]);
      m_last = 1;
    end else begin
      e_en = 0; e_we = 0;
    end
    if (acc) wq.push_back({SRAM_Addr_w, SRAM_Din});
    cyc++;
    e_rv = 1'b0;
    if (due_q.size() != 0 && due_q[0] == cyc) begin
      e_rv = 1'b1;
      e_rd = dat_q.pop_front();
      void'(due_q.pop_front());
    end
  endtask

  task automatic test_reset();
    sel = 0; m_depth = 4;
    for (int k = 0; k < 3; k++) begin
      Reset_n = 0; rd_req = 1; rd_addr = 20'h5; SRAM_EN_w = 1; SRAM_WE_w = 1;
      SRAM_Addr_w = 20'h7; SRAM_Din = 24'h1; write_finish = 0;
      #1; ref_cycle();
      n_cmp++; if (o_gnt !== 1'b0) begin n_bad++; $display("FAIL reset_gnt got %b want 0", o_gnt); end
      @(posedge clk); #1;
      n_cmp++; if (outs !== 73'd0) begin n_bad++; $display("FAIL reset_out got %h want 0", outs); end
    end
    Reset_n = 1; rd_req = 0; SRAM_Addr_w = 20'h123; SRAM_Din = 24'h456789;
    for (int k = 0; k < 5; k++) begin
      #1; ref_cycle();
      n_cmp++; if (o_gnt !== e_gr) begin n_bad++; $display("FAIL rst_rel_gnt cyc %0d got %b want %b", cyc, o_gnt, e_gr); end
      @(posedge clk); #1;
      n_cmp++; if (outs !== exps) begin n_bad++; $display("FAIL rst_rel_out cyc %0d got %h want %h", cyc, outs, exps); end
      if (k == 0) begin
        n_cmp++; if (o_en !== 1'b0) begin n_bad++; $display("FAIL first_wr_early got en=%b want 0", o_en); end
      end
      if (k == 1) begin
        n_cmp++;
        if ({o_en, o_we, o_addr, o_d} !== {1'b1, 1'b1, 20'h123, 24'h456789}) begin
          n_bad++; $display("FAIL first_wr_lat got %b%b %h %h want 11 00123 456789", o_en, o_we, o_addr, o_d);
        end
      end
      SRAM_EN_w = 0; SRAM_WE_w = 0;
    end
  endtask

  task automatic test_single_read();
    int gk;
    gk = -1;
    for (int k = 0; k < 14; k++) begin
      SRAM_EN_w = (k == 0); SRAM_WE_w = (k == 0);
      SRAM_Addr_w = 20'h00010; SRAM_Din = 24'hABCDEF;
      rd_req = (k >= 4 && gk < 0); rd_addr = 20'h00010;
      #1; ref_cycle();
      n_cmp++; if (o_gnt !== e_gr) begin n_bad++; $display("FAIL sread_gnt cyc %0d got %b want %b", cyc, o_gnt, e_gr); end
      if (o_gnt === 1'b1 && gk < 0) gk = k;
      @(posedge clk); #1;
      n_cmp++; if (outs !== exps) begin n_bad++; $display("FAIL sread_out cyc %0d got %h want %h", cyc, outs, exps); end
      if (gk >= 0 && k == gk) begin
        n_cmp++;
        if ({o_en, o_we, o_addr} !== {1'b1, 1'b0, 20'h00010}) begin
          n_bad++; $display("FAIL sread_cmd got %b%b %h want 10 00010", o_en, o_we, o_addr);
        end
      end
      if (gk >= 0 && k == gk + 1) begin
        n_cmp++; if (o_rv !== 1'b0) begin n_bad++; $display("FAIL sread_early got rv=%b want 0", o_rv); end
      end
      if (gk >= 0 && k == gk + 2) begin
        n_cmp++;
        if ({o_rv, o_rd} !== {1'b1, 24'hABCDEF}) begin
          n_bad++; $display("FAIL sread_data got rv=%b %h want rv=1 abcdef", o_rv, o_rd);
        end
      end
    end
    n_cmp++; if (gk != 4) begin n_bad++; $display("FAIL sread_gnt_cycle got %0d want 4", gk); end
  endtask

  task automatic test_contention();
    int wi, rq, nw, rv, bad;
    bit g;
    logic [DW-1:0] wd [16];
    wi = 0; rq = 0; nw = 0; rv = 0; bad = 0;
    rd_addr = AW'($urandom_range(0, 31));
    for (int k = 0; k < 50; k++) begin
      if (wi < 16) begin
        SRAM_EN_w = 1; SRAM_WE_w = 1; SRAM_Addr_w = AW'(wi);
        wd[wi] = DW'($urandom); SRAM_Din = wd[wi];
      end else begin
        SRAM_EN_w = 0; SRAM_WE_w = 0;
      end
      rd_req = (rq < 4);
      #1; ref_cycle();
      n_cmp++; if (o_gnt !== e_gr) begin n_bad++; $display("FAIL cont_gnt cyc %0d got %b want %b", cyc, o_gnt, e_gr); end
      g = (o_gnt === 1'b1);
      @(posedge clk); #1;
      n_cmp++; if (outs !== exps) begin n_bad++; $display("FAIL cont_out cyc %0d got %h want %h", cyc, outs, exps); end
      if (o_en === 1'b1 && o_we === 1'b1) begin
        n_cmp++; if (o_addr !== AW'(nw)) begin n_bad++; $display("FAIL cont_wr_order got %h want %h", o_addr, AW'(nw)); end
        nw++;
      end
      if (o_rv === 1'b1) rv++;
      if (wi < 16) wi++;
      if (g) begin rq++; rd_addr = AW'($urandom_range(0, 31)); end
    end
    n_cmp++; if (rv != 4)  begin n_bad++; $display("FAIL cont_reads got %0d want 4", rv); end
    n_cmp++; if (nw != 16) begin n_bad++; $display("FAIL cont_writes got %0d want 16", nw); end
    n_cmp++; if (o_ovf !== 1'b0) begin n_bad++; $display("FAIL cont_ovf got %b want 0", o_ovf); end
    for (int i = 0; i < 16; i++) if (sram[i] !== wd[i]) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL cont_mem got %0d wrong entries want 0", bad); end
  endtask

  task automatic test_overflow();
    bit g;
    sel = 1; m_depth = 2;
    for (int k = 0; k < 66; k++) begin
      Reset_n = (k >= 2);
      if (k < 6) begin
        SRAM_EN_w = 1; SRAM_WE_w = 1; rd_req = 1;
      end else begin
        SRAM_EN_w = ($urandom_range(0, 3) != 0); SRAM_WE_w = ($urandom_range(0, 7) != 0);
      end
      SRAM_Addr_w = AW'($urandom_range(0, 255)); SRAM_Din = DW'($urandom);
      #1; ref_cycle();
      n_cmp++; if (o_gnt !== e_gr) begin n_bad++; $display("FAIL ovf_gnt cyc %0d got %b want %b", cyc, o_gnt, e_gr); end
      g = (o_gnt === 1'b1);
      @(posedge clk); #1;
      n_cmp++; if (outs !== exps) begin n_bad++; $display("FAIL ovf_out cyc %0d got %h want %h", cyc, outs, exps); end
      if (k >= 5 && (g || !rd_req)) begin
        rd_req = $urandom_range(0, 1); rd_addr = AW'($urandom_range(0, 255));
      end
    end
  endtask

  task automatic test_reset_mid();
    sel = 0; m_depth = 4;
    for (int k = 0; k < 19; k++) begin
      Reset_n = !(k == 0 || k == 6 || k == 7);
      SRAM_EN_w = (k == 1 || k == 4 || k == 5 || k == 15); SRAM_WE_w = SRAM_EN_w;
      SRAM_Addr_w = AW'(20'h40 + k); SRAM_Din = DW'($urandom);
      rd_req = (k == 5); rd_addr = 20'h00010;
      #1; ref_cycle();
      n_cmp++; if (o_gnt !== e_gr) begin n_bad++; $display("FAIL mid_gnt cyc %0d got %b want %b", cyc, o_gnt, e_gr); end
      if (k == 5) begin
        n_cmp++; if (o_gnt !== 1'b1) begin n_bad++; $display("FAIL mid_rd_gnt got %b want 1", o_gnt); end
      end
      @(posedge clk); #1;
      n_cmp++; if (outs !== exps) begin n_bad++; $display("FAIL mid_out cyc %0d got %h want %h", cyc, outs, exps); end
      if (k >= 7 && k <= 15) begin
        n_cmp++; if ({o_en, o_rv} !== 2'b00) begin n_bad++; $display("FAIL mid_quiet k=%0d got en=%b rv=%b want 0 0", k, o_en, o_rv); end
      end
    end
  endtask

  task automatic test_completion();
    int last_wr, aw_k, bad;
    last_wr = -1; aw_k = -1; bad = 0;
    sel = 0; m_depth = 4; rd_req = 0;
    for (int k = 0; k < 65536 + 12; k++) begin
      Reset_n = (k != 0);
      SRAM_EN_w = (k >= 1 && k <= 65536); SRAM_WE_w = SRAM_EN_w;
      SRAM_Addr_w = AW'(k - 1); SRAM_Din = DW'(k - 1);
      write_finish = (k > 65536);
      #1; ref_cycle();
      n_cmp++; if (o_gnt !== e_gr) begin n_bad++; $display("FAIL done_gnt cyc %0d got %b want %b", cyc, o_gnt, e_gr); end
      @(posedge clk); #1;
      n_cmp++; if (outs !== exps) begin n_bad++; $display("FAIL done_out cyc %0d got %h want %h", cyc, outs, exps); end
      if (o_en === 1'b1 && o_we === 1'b1) last_wr = k;
      if (o_aw === 1'b1 && aw_k < 0) aw_k = k;
    end
    n_cmp++;
    if (aw_k < 0 || aw_k - last_wr != 2) begin
      n_bad++; $display("FAIL done_timing got aw at %0d last write at %0d want gap 2", aw_k, last_wr);
    end
    for (int i = 0; i < 65536; i++) if (sram[i] !== DW'(i)) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL done_frame got %0d wrong pixels want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_overflow();
    test_reset_mid();
    test_completion();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares the single-port pixel SRAM between the write controller, which fills the frame, and the rotation read controller, which fetches pixels in rotated order. Write commands pass through a small write buffer so that reads can take SRAM slots during the write phase. Reads follow a request/grant handshake with fixed-latency data return. The block drives the SRAM pins directly and reports when every accepted write has reached the SRAM.

## Interface

Parameters:
- `WBUF_DEPTH`, default 4: write-buffer entries (≥2).
- `SRAM_LAT`, default 1: cycles from the registered read command to valid `SRAM_Q` (≥1).
- `AW`, default 20: address width.
- `DW`, default 24: data width (RGB).

Ports:
- `Clk_in`, in, 1: the single clock.
- `Reset_n`, in, 1: synchronous, active-low reset, sampled on the rising edge of `Clk_in`.
- `SRAM_EN_w`, in, 1: write-controller enable.
- `SRAM_WE_w`, in, 1: write-controller write enable.
- `SRAM_Addr_w`, in, AW: write address.
- `SRAM_Din`, in, DW: write data.
- `write_finish`, in, 1: the write controller has issued its last pixel.
- `rd_req`, in, 1: read request, held until granted.
- `rd_addr`, in, AW: read address, stable while `rd_req` is high.
- `rd_gnt`, out, 1: combinational; the read request is accepted this cycle.
- `rd_valid`, out, 1: one-cycle pulse when read data is valid.
- `rd_data`, out, DW: read data.
- `SRAM_EN`, out, 1: SRAM enable.
- `SRAM_WE`, out, 1: SRAM write enable.
- `SRAM_Addr`, out, AW: SRAM address.
- `SRAM_D`, out, DW: SRAM write data.
- `SRAM_Q`, in, DW: SRAM read data.
- `wbuf_overflow`, out, 1: sticky; a write was dropped.
- `all_written`, out, 1: the write phase is complete and fully drained.

## Operation

- **Push.** A write is pushed when `SRAM_EN_w & SRAM_WE_w`.
  - The entry {addr, data} goes into a FIFO of `WBUF_DEPTH` entries.
  - The push is accepted if `count < WBUF_DEPTH`, or if a pop happens in the same cycle.
  - Otherwise the write is dropped and `wbuf_overflow` is set to 1 until reset.
- **Pending requests.** Write is pending when `count ≠ 0`, where `count` is the value before this cycle's push. Read is pending when `rd_req` is high.
- **Arbitration (per cycle, combinational):**
  - If `count ≥ WBUF_DEPTH-1`, grant write (forced).
  - Else if both are pending, grant the one that is not `last_gnt`.
  - Else grant whichever is pending; if neither is pending, the SRAM is idle.
  - `last_gnt` updates only on a grant (0 = write, 1 = read). Its reset value is 1, so the first contention goes to write.
- **Write grant.**
  - Pop the FIFO head.
  - Next cycle: `SRAM_EN=1`, `SRAM_WE=1`, `SRAM_Addr`=head address, `SRAM_D`=head data.
- **Read grant.**
  - `rd_gnt=1` in the same cycle.
  - Next cycle: `SRAM_EN=1`, `SRAM_WE=0`, `SRAM_Addr=rd_addr`, `SRAM_D` holds its previous value.
- **Read return.**
  - A `SRAM_LAT`-deep valid shift register tracks each read command.
  - `SRAM_Q` is captured into `rd_data` when its tag emerges.
  - `rd_valid` pulses for 1 cycle; `rd_data` holds until the next capture.
- **Idle cycle.** `SRAM_EN=0`, `SRAM_WE=0`. `SRAM_Addr` and `SRAM_D` hold their previous values.
- **Completion.**
  - `all_written` is set when `write_finish` is high, `count==0`, no push is occurring, and no write command is on the SRAM pins.
  - `all_written` is sticky until reset.
- **Reset.** Values while `Reset_n=0` at a clock edge:
  - FIFO emptied (`count=0`, pointers 0).
  - `last_gnt=1`.
  - Read shift register cleared; in-flight reads are discarded with no `rd_valid`.
  - All outputs 0: `SRAM_EN`, `SRAM_WE`, `SRAM_Addr`, `SRAM_D`, `rd_valid`, `rd_data`, `wbuf_overflow`, `all_written`.
  - `rd_gnt=0` while reset is asserted.

## Timing

- **Write latency.** A write pushed at edge of cycle m, into an empty FIFO with no read pending, appears on the SRAM pins in cycle m+2.
- **Read latency.** For `rd_gnt` in cycle n:
  - Command on the pins in cycle n+1.
  - `SRAM_Q` valid in cycle n+1+`SRAM_LAT`.
  - `rd_valid` in cycle n+2+`SRAM_LAT`, which is n+3 at default.
- **Throughput.**
  - At most one SRAM command per cycle.
  - Reads are pipelined back-to-back, with one `rd_valid` per grant in order.
- **Continuous write stream** (1 write/cycle):
  - With read contention, `count` climbs to `WBUF_DEPTH-1`.
  - Writes are then forced every cycle and reads stall until a line gap.
  - No overflow occurs in this case.
- **Simultaneous push and pop at `count==WBUF_DEPTH`:** the push is accepted and `count` is unchanged.
- **Pointers** wrap modulo `WBUF_DEPTH`. Any depth is allowed; the wrap is explicit, not a power-of-2 mask.

## Test plan

1. **Reset.** Hold `Reset_n=0` for 3 cycles with `rd_req=1` and write enables high → all outputs 0, `rd_gnt=0`. After release, the first write reaches the pins 2 cycles after its push.
2. **Single read.** `rd_req` with `rd_addr=0x00010`, no writes, SRAM model returning `0xABCDEF` at that address → `rd_gnt` in cycle n; `SRAM_EN=1`, `SRAM_WE=0`, `SRAM_Addr=0x00010` in n+1; `rd_valid=1`, `rd_data=0xABCDEF` in n+3.
3. **Contention.** Writes to addresses 0..15 every cycle, with `rd_req` held high for 4 reads → grants alternate W,R,W,R until `count` reaches 3; then writes are forced. All 16 writes land in address order, the 4 reads return in order, and `wbuf_overflow=0`.
4. **Overflow.**
   - Setup: parameter override `WBUF_DEPTH=2`, `rd_req` high, 4 consecutive pushes.
   - Each push is accepted only when `count<2` or a pop happens in the same cycle.
   - Checks: verify `wbuf_overflow` matches a reference model; once set, it stays 1.
5. **Reset mid-operation.** Assert reset 1 cycle after `rd_gnt` with 2 entries buffered → no `rd_valid`, no buffered writes issued, `count=0` after release.
6. **Completion.**
   - Stimulus: 256×256 frame, `write_finish` high after the last push.
   - `all_written` rises exactly 1 cycle after the last write command leaves the pins, with the FIFO empty.
   - The SRAM model holds pixel i at address i for every i.
